// File: rtl/memory_controller.sv
// memory_controller
//   Address decoder and data router between the core's single load/store port and the
//   four backing regions (code ROM, data RAM, switch input word, output map). Routes each
//   access to exactly one region, gates write strobes, masks read data to the access size
//   and flags illegal accesses. The read path is combinational; only memory_error is a flop.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   address, write_enable,   core request: byte address, write request,
//   data_size, data_in       size (0=byte 1=half 2=word 3=illegal), right-aligned write data
//   data_out, memory_error   zero-extended read data, registered fault flag
//   code_in / code_address                   code ROM read word / byte offset
//   memory_in / memory_address / memory_out / memory_size / memory_write_enable   data RAM
//   input_in                                 switch input word
//   output_in / output_address / output_out / output_size / output_write_enable   output map
module memory_controller #(
    parameter logic [31:0] CODE_BASE   = 32'h0000_0000,
    parameter int unsigned CODE_SIZE   = 256,
    parameter logic [31:0] RAM_BASE    = 32'h0001_0000,
    parameter int unsigned RAM_SIZE    = 65536,
    parameter logic [31:0] INPUT_BASE  = 32'h0002_0000,
    parameter logic [31:0] OUTPUT_BASE = 32'h0002_0010,
    parameter int unsigned OUTPUT_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        memory_error,
    input  logic [31:0] code_in,
    output logic [31:0] code_address,
    input  logic [31:0] memory_in,
    output logic [31:0] memory_address,
    output logic [31:0] memory_out,
    output logic [1:0]  memory_size,
    output logic        memory_write_enable,
    input  logic [31:0] input_in,
    input  logic [31:0] output_in,
    output logic [31:0] output_address,
    output logic [31:0] output_out,
    output logic [1:0]  output_size,
    output logic        output_write_enable
);

    // Region bounds in 33 bits so base+size and address+bytes-1 cannot wrap.
    localparam logic [32:0] CODE_LO = {1'b0, CODE_BASE};
    localparam logic [32:0] CODE_HI = CODE_LO + 33'(CODE_SIZE);
    localparam logic [32:0] RAM_LO  = {1'b0, RAM_BASE};
    localparam logic [32:0] RAM_HI  = RAM_LO + 33'(RAM_SIZE);
    localparam logic [32:0] IN_LO   = {1'b0, INPUT_BASE};
    localparam logic [32:0] IN_HI   = IN_LO + 33'd4;
    localparam logic [32:0] OUT_LO  = {1'b0, OUTPUT_BASE};
    localparam logic [32:0] OUT_HI  = OUT_LO + 33'(OUTPUT_SIZE);

    logic [2:0]  nbytes;
    logic [32:0] first, last;
    logic        hit_code, hit_ram, hit_in, hit_out;
    logic        misaligned, fault;
    logic        sel_code, sel_ram, sel_in, sel_out;
    logic [31:0] size_mask, rd_raw;

    always_comb begin
        case (data_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        first = {1'b0, address};
        last  = first + {30'b0, nbytes} - 33'd1;

        // A straddling access fails the 'last' bound, so it hits nothing and faults.
        hit_code = (first >= CODE_LO) && (last < CODE_HI);
        hit_ram  = (first >= RAM_LO)  && (last < RAM_HI);
        hit_in   = (first >= IN_LO)   && (last < IN_HI);
        hit_out  = (first >= OUT_LO)  && (last < OUT_HI);

        misaligned = ((data_size == 2'd1) && address[0]) ||
                     ((data_size == 2'd2) && (address[1:0] != 2'b00));

        fault = (data_size == 2'd3) ||
                !(hit_code || hit_ram || hit_in || hit_out) ||
                (misaligned && !hit_code) ||
                (write_enable && (hit_code || hit_in));

        sel_code = hit_code && !fault;
        sel_ram  = hit_ram  && !fault;
        sel_in   = hit_in   && !fault;
        sel_out  = hit_out  && !fault;

        case (data_size)
            2'd0:    size_mask = 32'h0000_00FF;
            2'd1:    size_mask = 32'h0000_FFFF;
            default: size_mask = '1;
        endcase

        rd_raw = '0;
        if (sel_code) rd_raw = code_in;
        if (sel_ram)  rd_raw = memory_in;
        if (sel_in)   rd_raw = input_in >> {address[1:0], 3'b000};
        if (sel_out)  rd_raw = output_in;

        data_out = (rst && !write_enable) ? (rd_raw & size_mask) : '0;

        code_address = sel_code ? (address - CODE_BASE) : '0;

        memory_address      = sel_ram ? (address - RAM_BASE) : '0;
        memory_out          = sel_ram ? data_in : '0;
        memory_size         = sel_ram ? data_size : '0;
        memory_write_enable = sel_ram && write_enable && rst;

        output_address      = sel_out ? (address - OUTPUT_BASE) : '0;
        output_out          = sel_out ? data_in : '0;
        output_size         = sel_out ? data_size : '0;
        output_write_enable = sel_out && write_enable && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) memory_error <= 1'b0;
        else      memory_error <= fault;
    end

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller
//   Directed vectors with hand-computed expectations for memory_controller.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic        write_enable = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        memory_error;
    logic [31:0] code_in = '0;
    logic [31:0] code_address;
    logic [31:0] memory_in = '0;
    logic [31:0] memory_address;
    logic [31:0] memory_out;
    logic [1:0]  memory_size;
    logic        memory_write_enable;
    logic [31:0] input_in = '0;
    logic [31:0] output_in = '0;
    logic [31:0] output_address;
    logic [31:0] output_out;
    logic [1:0]  output_size;
    logic        output_write_enable;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_controller dut (
        .clk(clk), .rst(rst),
        .address(address), .write_enable(write_enable), .data_size(data_size),
        .data_in(data_in), .data_out(data_out), .memory_error(memory_error),
        .code_in(code_in), .code_address(code_address),
        .memory_in(memory_in), .memory_address(memory_address), .memory_out(memory_out),
        .memory_size(memory_size), .memory_write_enable(memory_write_enable),
        .input_in(input_in),
        .output_in(output_in), .output_address(output_address), .output_out(output_out),
        .output_size(output_size), .output_write_enable(output_write_enable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an access away from the clock edge and let the comb path settle.
    task automatic access(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic [31:0] d);
        @(negedge clk);
        address = a; write_enable = we; data_size = sz; data_in = d;
        #1;
    endtask

    task automatic err_after_edge(input string tag, input logic exp);
        @(posedge clk);
        #1;
        check(tag, {31'b0, memory_error}, {31'b0, exp});
    endtask

    initial begin
        code_in   = 32'hDEAD_BEEF;
        memory_in = 32'hCAFE_BABE;
        output_in = 32'h8765_4321;

        // Reset state
        #2;
        check("rst_err", {31'b0, memory_error}, 32'h0);
        check("rst_dout", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Code word read
        access(32'h0000_0004, 1'b0, 2'd2, 32'h0);
        check("code_addr", code_address, 32'h4);
        check("code_dout", data_out, 32'hDEAD_BEEF);
        check("code_ram_addr", memory_address, 32'h0);
        err_after_edge("code_err", 1'b0);

        // Unaligned code read is legal
        access(32'h0000_0003, 1'b0, 2'd1, 32'h0);
        check("code_unal_addr", code_address, 32'h3);
        check("code_unal_dout", data_out, 32'h0000_BEEF);
        err_after_edge("code_unal_err", 1'b0);

        // RAM byte write
        access(32'h0001_0013, 1'b1, 2'd0, 32'h1234_56AB);
        check("ram_wr_addr", memory_address, 32'h13);
        check("ram_wr_we", {31'b0, memory_write_enable}, 32'h1);
        check("ram_wr_data", memory_out, 32'h1234_56AB);
        check("ram_wr_size", {30'b0, memory_size}, 32'h0);
        check("ram_wr_dout", data_out, 32'h0);
        check("ram_wr_owe", {31'b0, output_write_enable}, 32'h0);
        err_after_edge("ram_wr_err", 1'b0);

        // RAM half read, masked
        access(32'h0001_0020, 1'b0, 2'd1, 32'h0);
        check("ram_rd_dout", data_out, 32'h0000_BABE);
        check("ram_rd_size", {30'b0, memory_size}, 32'h1);
        check("ram_rd_out0", output_address, 32'h0);

        // Last RAM word is legal
        access(32'h0001_FFFC, 1'b0, 2'd2, 32'h0);
        check("ram_end_addr", memory_address, 32'h0000_FFFC);
        err_after_edge("ram_end_err", 1'b0);

        // Input half reads
        input_in = 32'h0000_A5C3;
        access(32'h0002_0002, 1'b0, 2'd1, 32'h0);
        check("in_half2", data_out, 32'h0);
        access(32'h0002_0000, 1'b0, 2'd1, 32'h0);
        check("in_half0", data_out, 32'h0000_A5C3);
        input_in = 32'h1122_3344;
        access(32'h0002_0001, 1'b0, 2'd0, 32'h0);
        check("in_byte1", data_out, 32'h33);
        err_after_edge("in_err", 1'b0);

        // Output word write and read
        access(32'h0002_0014, 1'b1, 2'd2, 32'h0BAD_F00D);
        check("out_wr_addr", output_address, 32'h4);
        check("out_wr_owe", {31'b0, output_write_enable}, 32'h1);
        check("out_wr_mwe", {31'b0, memory_write_enable}, 32'h0);
        check("out_wr_data", output_out, 32'h0BAD_F00D);
        check("out_wr_size", {30'b0, output_size}, 32'h2);
        access(32'h0002_001C, 1'b0, 2'd2, 32'h0);
        check("out_rd_dout", data_out, 32'h8765_4321);

        // Faults
        access(32'h0000_0010, 1'b1, 2'd2, 32'hFFFF_FFFF);
        check("f_codewr_mwe", {31'b0, memory_write_enable}, 32'h0);
        check("f_codewr_caddr", code_address, 32'h0);
        check("f_codewr_dout", data_out, 32'h0);
        err_after_edge("f_codewr_err", 1'b1);

        access(32'h0001_0002, 1'b0, 2'd2, 32'h0);
        check("f_unal_dout", data_out, 32'h0);
        check("f_unal_maddr", memory_address, 32'h0);
        err_after_edge("f_unal_err", 1'b1);

        access(32'h0003_0000, 1'b0, 2'd0, 32'h0);
        check("f_nohit_dout", data_out, 32'h0);
        err_after_edge("f_nohit_err", 1'b1);

        access(32'h0001_0000, 1'b1, 2'd3, 32'h55);
        check("f_size3_mwe", {31'b0, memory_write_enable}, 32'h0);
        check("f_size3_mout", memory_out, 32'h0);
        err_after_edge("f_size3_err", 1'b1);

        access(32'h0000_00FE, 1'b0, 2'd2, 32'h0);
        check("f_straddle_dout", data_out, 32'h0);
        err_after_edge("f_straddle_err", 1'b1);

        access(32'h0002_0000, 1'b1, 2'd2, 32'h1);
        err_after_edge("f_inwr_err", 1'b1);

        access(32'h0001_0000, 1'b0, 2'd2, 32'h0);
        err_after_edge("f_clear_err", 1'b0);

        // Reset asserted mid-fault
        access(32'h0003_0000, 1'b0, 2'd2, 32'h0);
        err_after_edge("r_fault_err", 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("r_async_clr", {31'b0, memory_error}, 32'h0);
        access(32'h0001_0040, 1'b1, 2'd2, 32'hA5A5_A5A5);
        check("r_mwe_low", {31'b0, memory_write_enable}, 32'h0);
        check("r_addr_dec", memory_address, 32'h40);
        err_after_edge("r_err_held", 1'b0);
        access(32'h0001_0040, 1'b0, 2'd2, 32'h0);
        check("r_dout_low", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        address = 32'h0001_0040; write_enable = 1'b1; data_size = 2'd2;
        #1;
        check("r_mwe_rel", {31'b0, memory_write_enable}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
